dct_zigzag_buf: RTL and testbench
=================================

Name: dct_zigzag_buf

Overview:
- Downstream neighbour of dct_idct. Consumes the serial 12-bit 2-D DCT coefficient stream (dct_2d), which arrives row-major, 64 coefficients per 8x8 block.
- Reorders each block into JPEG zigzag order through a ping-pong pair of 64-entry banks.
- Emits coefficients over a valid/ready interface to the quantiser/entropy-coder stage.
- The DCT stream cannot stall, so the block absorbs downstream backpressure up to one full block and flags overflow beyond that.

Parameters:
- COEF_W, 12, coefficient width, two's complement, matches dct_2d.
- BLK_N, 64, coefficients per block; fixed at 64, present for package consistency.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- din  in  COEF_W  coefficient from dct_idct.dct_2d.
- din_valid  in  1  din carries a coefficient this cycle.
- din_sof  in  1  with din_valid: din is coefficient (0,0) of a new block.
- dout  out  COEF_W  zigzag-ordered coefficient.
- dout_valid  out  1  dout holds a coefficient.
- dout_ready  in  1  downstream accepts when high together with dout_valid.
- dout_sob  out  1  dout is zigzag index 0.
- dout_eob  out  1  dout is zigzag index 63.
- overflow  out  1  sticky: a block was dropped because no bank was free.
- sof_err  out  1  sticky: din_sof arrived mid-block.

Behaviour:
- Reset (RST=0, async): all outputs 0, both banks empty, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, read FSM in IDLE. Takes effect immediately, including mid-block.
- Write side:
  - Each din_valid writes din to bank[wr_bank][wr_cnt], then wr_cnt increments.
  - din_sof with din_valid forces write index 0. If wr_cnt!=0 at that point, the partial block is discarded and sof_err is set.
  - din_valid without din_sof while wr_cnt==0 is ignored; this prevents start-up misalignment.
  - On the write at index 63, bank[wr_bank] is marked full and wr_bank toggles.
- Bank allocation:
  - At each sof, the target bank must be empty, or be released by the reader in that same cycle.
  - Otherwise the whole block is dropped (no writes) and overflow is set. Writing resumes at the next sof that finds a free bank.
- Read FSM, two states:
  - IDLE: when bank[rd_bank] is full, go to READ and issue address ZZ[0].
  - READ: each accepted transfer advances rd_cnt; the read address is ZZ[rd_cnt].
  - After index 63 is accepted: release bank[rd_bank], toggle rd_bank, rd_cnt=0. Go to IDLE, or stay in READ with no bubble if the other bank is already full.
- Output register and handshake:
  - dout, dout_sob and dout_eob are registered.
  - While dout_valid=1 and dout_ready=0, all outputs hold stable.
  - No combinational path from dout_ready to dout_valid.
- Latency and throughput:
  - Write of index 63 in cycle N gives dout_valid=1 with index 0 in cycle N+2.
  - With dout_ready tied high, one coefficient per cycle. This sustains continuous back-to-back input indefinitely.
- Arithmetic: data is passed unmodified, full COEF_W, sign preserved.
- Simultaneous events: a read release and a write allocation on the same bank in one cycle count as free. A write completing one bank while the other bank is released is legal.

Optional Feature:
- Macro: DCT_ZZ_QUANT_EN.
- When defined: dout = coefficient arithmetically right-shifted by QSHIFT[zigzag index], rounded toward zero (add 2^s-1 before shifting when negative). Adds zero latency; the shift is applied before the output register.
- When undefined: pass-through.

Decomposition:
- Package dct_pkg holds:
  - COEF_W and BLK_N;
  - the 64-entry zigzag-to-raster table ZZ (6-bit entries);
  - the 64-entry QSHIFT table (3-bit entries);
  - the read FSM state enum.
- One natural sub-module: dct_zz_bank, a 64xCOEF_W register bank with one write port and one read port, instantiated twice. Control stays in the top.

Test Plan:
- Ramp: one block with din=0..63, sof on the first, dout_ready=1 -> dout sequence 0,1,8,16,9,2,3,10,17,24,...,62,63. sob on 0, eob on 63. First dout_valid 2 cycles after the write of 63.
- Continuous: 4 back-to-back blocks using the image data (first values 0x028, 0x021, 0x021, 0x016, ...), dout_ready=1 -> 256 outputs, no gaps after the first, overflow=0. The block 1 sequence starts 0x028, 0x021, 0x02B.
- Backpressure: dout_ready toggles 1/0 every cycle on the ramp block -> no loss or duplication, dout stable while stalled, 64 transfers total.
- Overflow: dout_ready=0, three blocks sent -> overflow=1, third block dropped. Then dout_ready=1 -> only blocks 1 and 2 emerge, in order.
- Misaligned sof: sof at indices 0 and then 20, followed by a full block -> sof_err=1, first partial block never emitted, second block emitted intact. Negative value 0xF9C (-100) passes unchanged.
- Reset mid-read: RST low during output index 30 -> dout_valid=0 immediately. After release, a new ramp block outputs correctly from index 0. With DCT_ZZ_QUANT_EN and QSHIFT[0]=3, din=-100 at index 0 -> dout=-12.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, zigzag/quant tables and read FSM state type
// for the DCT coefficient zigzag reorder buffer.
// Optional DCT_ZZ_QUANT_EN enables the per-index shift helper in the top.
package dct_pkg;

  localparam int COEF_W = 12;
  localparam int BLK_N  = 64;

  // Zigzag index -> raster (row-major) index within an 8x8 block.
  localparam logic [0:BLK_N-1][5:0] ZZ = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Right-shift per zigzag index: coarser quantisation at higher frequencies.
  localparam logic [0:BLK_N-1][2:0] QSHIFT = {
    3'd3, {5{3'd1}}, {9{3'd2}}, {21{3'd3}}, {28{3'd4}}
  };

  typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

  // Arithmetic shift right, rounding toward zero (bias negatives by 2^s-1).
  function automatic logic [COEF_W-1:0] qshift_rtz(input logic [COEF_W-1:0] v,
                                                   input logic [2:0] s);
    logic signed [COEF_W-1:0] sv;
    logic signed [COEF_W-1:0] bias;
    sv   = signed'(v);
    bias = v[COEF_W-1] ? signed'((COEF_W'(1) << s) - COEF_W'(1)) : '0;
    return COEF_W'((sv + bias) >>> s);
  endfunction

endpackage

// File: rtl/dct_zz_bank.sv
// dct_zz_bank: 64 x COEF_W register bank, one synchronous write port and
// one combinational read port. Holds one 8x8 block in raster order.
module dct_zz_bank
  import dct_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [5:0]        i_waddr,
  input  logic [COEF_W-1:0] i_wdata,
  input  logic [5:0]        i_raddr,
  output logic [COEF_W-1:0] o_rdata
);

  logic [COEF_W-1:0] r_mem [BLK_N];

  // Storage write; contents need no reset, validity is tracked by the owner.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dct_zigzag_buf.sv
// dct_zigzag_buf: reorders the row-major DCT coefficient stream into JPEG
// zigzag order through two ping-pong banks and emits it over valid/ready.
// Absorbs up to one block of backpressure; a block with no free bank is
// dropped and flagged on overflow.
// Optional macro DCT_ZZ_QUANT_EN: shift each output by QSHIFT[zigzag index].
module dct_zigzag_buf
  import dct_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [COEF_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_sof,
  output logic [COEF_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sob,
  output logic              dout_eob,
  output logic              overflow,
  output logic              sof_err
);

  // Write side
  logic              r_wr_bank;
  logic [5:0]        r_wr_cnt;
  logic [1:0]        r_full;
  logic              r_overflow;
  logic              r_sof_err;
  // Read side
  rd_state_e         r_state, w_state_nxt;
  logic              r_rd_bank;
  logic [5:0]        r_rd_cnt;
  logic              w_fetch;
  // Output register
  logic [COEF_W-1:0] r_dout;
  logic              r_dv, r_sob, r_eob, r_obank;

  logic              w_adv, w_rel, w_wr_free, w_we, w_wr_last;
  logic [1:0]        w_rel_vec, w_set_vec;
  logic [5:0]        w_waddr;
  logic [COEF_W-1:0] w_rdat [2];
  logic [COEF_W-1:0] w_rdat_sel, w_qdat;

  // A bank is freed when the eob coefficient leaves the output register.
  assign w_rel     = r_dv & dout_ready & r_eob;
  assign w_rel_vec = {w_rel & r_obank, w_rel & ~r_obank};

  // sof may claim a bank that the reader releases in the same cycle.
  assign w_wr_free = ~r_full[r_wr_bank] | w_rel_vec[r_wr_bank];
  // wr_cnt==0 without sof means "not inside an accepted block": ignore.
  assign w_we      = din_valid & (din_sof ? w_wr_free : (r_wr_cnt != 6'd0));
  assign w_waddr   = din_sof ? 6'd0 : r_wr_cnt;
  assign w_wr_last = din_valid & ~din_sof & (r_wr_cnt == 6'd63);
  assign w_set_vec = {w_wr_last & r_wr_bank, w_wr_last & ~r_wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_zz_bank u_bank (
      .i_clk   (CLK),
      .i_we    (w_we & (r_wr_bank == 1'(b))),
      .i_waddr (w_waddr),
      .i_wdata (din),
      .i_raddr (ZZ[r_rd_cnt]),
      .o_rdata (w_rdat[b])
    );
  end

  assign w_rdat_sel = w_rdat[r_rd_bank];

`ifdef DCT_ZZ_QUANT_EN
  assign w_qdat = qshift_rtz(w_rdat_sel, QSHIFT[r_rd_cnt]);
`else
  assign w_qdat = w_rdat_sel;
`endif

  // Output register can take a new coefficient when empty or being drained.
  assign w_adv = ~r_dv | dout_ready;

  // Write pointer, bank toggle and sticky error flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_overflow <= 1'b0;
      r_sof_err  <= 1'b0;
    end else if (din_valid) begin
      if (din_sof) begin
        if (r_wr_cnt != 6'd0) r_sof_err <= 1'b1;
        if (w_wr_free) begin
          r_wr_cnt <= 6'd1;
        end else begin
          r_wr_cnt   <= 6'd0;
          r_overflow <= 1'b1;
        end
      end else if (r_wr_cnt != 6'd0) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (r_wr_cnt == 6'd63) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Bank full flags: set by the writer on index 63, cleared on release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_full <= '0;
    else      r_full <= (r_full & ~w_rel_vec) | w_set_vec;
  end

  // Read FSM next state and fetch strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank] && w_adv) begin
          w_fetch     = 1'b1;
          w_state_nxt = RD_READ;
        end
      end
      RD_READ: begin
        if (w_adv) begin
          w_fetch = 1'b1;
          if (r_rd_cnt == 6'd63)
            w_state_nxt = r_full[~r_rd_bank] ? RD_READ : RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM state and read pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= RD_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fetch) begin
        r_rd_cnt <= r_rd_cnt + 6'd1;
        if (r_rd_cnt == 6'd63) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Output register; holds everything while stalled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_sob   <= 1'b0;
      r_eob   <= 1'b0;
      r_obank <= 1'b0;
    end else if (w_fetch) begin
      r_dout  <= w_qdat;
      r_dv    <= 1'b1;
      r_sob   <= (r_rd_cnt == 6'd0);
      r_eob   <= (r_rd_cnt == 6'd63);
      r_obank <= r_rd_bank;
    end else if (dout_ready) begin
      r_dv  <= 1'b0;
      r_sob <= 1'b0;
      r_eob <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign dout_sob   = r_sob;
  assign dout_eob   = r_eob;
  assign overflow   = r_overflow;
  assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// tb_dct_zigzag_buf: directed stimulus with a scoreboard queue; a monitor
// pops and compares every accepted output and checks hold-while-stalled.
module tb_dct_zigzag_buf;
  localparam int W = 12;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_sof = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid, dout_sob, dout_eob, overflow, sof_err;

  dct_zigzag_buf dut (
    .CLK        (CLK),
    .RST        (RST),
    .din        (din),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sob   (dout_sob),
    .dout_eob   (dout_eob),
    .overflow   (overflow),
    .sof_err    (sof_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] d;
    logic         sob;
    logic         eob;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           n_xfer = 0;
  logic [W-1:0] blk[64];

  // Expected ramp output: zigzag k carries raster index RZZ[k].
  int RZZ[64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
   12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
   35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
   58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  function automatic int qs(int k);
    if (k == 0)      return 3;
    else if (k < 6)  return 1;
    else if (k < 15) return 2;
    else if (k < 36) return 3;
    else             return 4;
  endfunction

  function automatic logic [W-1:0] model(logic [W-1:0] v, int k);
    int s, sv, r;
    s = qs(k);
`ifndef DCT_ZZ_QUANT_EN
    s = 0;
`endif
    sv = v[W-1] ? int'(v) - 4096 : int'(v);
    r  = (sv < 0) ? ((sv + (1 << s) - 1) >>> s) : (sv >>> s);
    return W'(r);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) blk[i] = W'(i);
  endtask

  task automatic fill_img(int b);
    for (int i = 0; i < 64; i++) blk[i] = W'((i * 53 + b * 97) % 200 - 100);
    if (b == 0) begin
      blk[0] = 12'h028; blk[1] = 12'h021; blk[2] = 12'h021;
      blk[3] = 12'h016; blk[8] = 12'h02B;
    end
  endtask

  task automatic push_blk();
    for (int k = 0; k < 64; k++)
      q.push_back('{d: model(blk[RZZ[k]], k), sob: (k == 0), eob: (k == 63)});
  endtask

  task automatic send(int n, bit sof);
    for (int i = 0; i < n; i++) begin
      din       = blk[i];
      din_valid = 1'b1;
      din_sof   = (i == 0) && sof;
      @(posedge CLK); #1;
    end
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic do_reset();
    RST       = 1'b0;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic drain(string name);
    int t;
    t = 0;
    while ((q.size() != 0 || dout_valid) && t < 2000) begin
      @(posedge CLK); t++;
    end
    repeat (4) @(posedge CLK);
    #1 chk({name, " drain"}, q.size(), 0);
  endtask

  task automatic count_valid();
    int t, v;
    t = 0; v = 0;
    @(negedge CLK);
    while (!dout_valid && t < 400) begin @(negedge CLK); t++; end
    for (int i = 0; i < 256; i++) begin
      if (dout_valid) v++;
      @(negedge CLK);
    end
    chk("continuous valid cycles", v, 256);
  endtask

  task automatic toggle_ready(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1 dout_ready = ~dout_ready;
    end
  endtask

  task automatic monitor();
    exp_t         e;
    logic         stall;
    logic [W+1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!dout_valid || {dout, dout_sob, dout_eob} !== held) begin
            errors++;
            $display("FAIL hold: got %h valid %b expected %h valid 1",
                     {dout, dout_sob, dout_eob}, dout_valid, held);
          end
        end
        if (dout_valid && dout_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected output: got %h, none expected", dout);
          end else begin
            e = q.pop_front();
            n_xfer++;
            if ({dout, dout_sob, dout_eob} !== {e.d, e.sob, e.eob}) begin
              errors++;
              $display("FAIL xfer %0d: got %h sob %b eob %b expected %h sob %b eob %b",
                       n_xfer, dout, dout_sob, dout_eob, e.d, e.sob, e.eob);
            end
          end
        end
        stall = dout_valid && !dout_ready;
        held  = {dout, dout_sob, dout_eob};
      end
    end
  endtask

  initial begin
    int t, x0;
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst dout_valid", dout_valid, 0);
    chk("rst dout",       dout,       0);
    chk("rst sob",        dout_sob,   0);
    chk("rst eob",        dout_eob,   0);
    chk("rst overflow",   overflow,   0);
    chk("rst sof_err",    sof_err,    0);
    @(posedge CLK); #1 RST = 1'b1;

    // Ramp block with latency check
    dout_ready = 1'b1;
    fill_ramp(); push_blk(); send(64, 1);
    @(negedge CLK); chk("lat N+1 valid", dout_valid, 0);
    @(negedge CLK); chk("lat N+2 valid", dout_valid, 1);
    chk("lat N+2 dout", dout, 0);
    chk("lat N+2 sob", dout_sob, 1);
    drain("ramp");
    chk("ramp xfers", n_xfer, 64);

    // Continuous back-to-back blocks
    x0 = n_xfer;
    fork
      begin
        for (int b = 0; b < 4; b++) begin fill_img(b); push_blk(); send(64, 1); end
      end
      count_valid();
    join
    drain("continuous");
    chk("continuous xfers", n_xfer - x0, 256);
    chk("continuous overflow", overflow, 0);

    // Backpressure: ready toggles every cycle
    x0 = n_xfer;
    fill_ramp(); push_blk();
    fork
      send(64, 1);
      toggle_ready(260);
    join
    dout_ready = 1'b1;
    drain("backpressure");
    chk("backpressure xfers", n_xfer - x0, 64);

    // Misaligned sof: partial block discarded, next block intact
    do_reset();
    dout_ready = 1'b1;
    x0 = n_xfer;
    fill_img(5); send(20, 1);
    fill_img(6); blk[0] = 12'hF9C; push_blk(); send(64, 1);
    drain("misaligned");
    chk("misaligned sof_err", sof_err, 1);
    chk("misaligned overflow", overflow, 0);
    chk("misaligned xfers", n_xfer - x0, 64);

    // Overflow: third block dropped while output stalled
    do_reset();
    dout_ready = 1'b0;
    x0 = n_xfer;
    fill_img(1); push_blk(); send(64, 1);
    fill_img(2); push_blk(); send(64, 1);
    fill_img(3); send(64, 1);
    repeat (3) @(posedge CLK);
    #1;
    chk("overflow flag", overflow, 1);
    chk("overflow stalled valid", dout_valid, 1);
    chk("overflow sof_err", sof_err, 0);
    dout_ready = 1'b1;
    drain("overflow");
    chk("overflow xfers", n_xfer - x0, 128);

    // Reset while index 30 is on the output
    fill_ramp(); push_blk(); send(64, 1);
    t = 0;
    while (!(dout_valid && dout == 12'd21) && t < 100) begin
      @(posedge CLK); #2; t++;
    end
    chk("idx30 reached", (t < 100), 1);
    RST = 1'b0;
    q.delete();
    #1;
    chk("midrst dout_valid", dout_valid, 0);
    chk("midrst dout", dout, 0);
    chk("midrst overflow", overflow, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    x0 = n_xfer;
    fill_ramp(); push_blk(); send(64, 1);
    drain("after reset");
    chk("after reset xfers", n_xfer - x0, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
